// File: rtl/gba_irq_scheduler.sv
// gba_irq_scheduler: delays and prioritises interrupts toward the ARM7 core,
// holds the IRQ line until acknowledged, and sequences HALT/STOP/wake.
//
// Handshake: cpu_irq is a level that stays high until the CPU pulses
// cpu_irq_ack for one cycle or the pending vector disappears; halt_req,
// stop_req and cpu_irq_ack are single-cycle pulses sampled on the rising
// edge and only honoured in the states that accept them.
module gba_irq_scheduler #(
  parameter int unsigned IRQ_DELAY  = 3,
  parameter int unsigned WAKE_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] irq_pending,
  input  logic        ime,
  input  logic        cpu_irq_ack,
  input  logic        halt_req,
  input  logic        stop_req,
  input  logic        halt_cycles_clr,
  output logic        cpu_irq,
  output logic [3:0]  irq_source,
  output logic        halt,
  output logic        stop,
  output logic [31:0] halt_cycles,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_DELAY  = 3'd1,
    S_ASSERT = 3'd2,
    S_HALT   = 3'd3,
    S_STOP   = 3'd4,
    S_WAKE   = 3'd5
  } state_t;

  // Counter preload values; unused when the matching delay is zero.
  localparam logic [3:0] IRQ_LOAD  = 4'(IRQ_DELAY - 1);
  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_DELAY - 1);

  // Only Keypad (12), GamePak (13) and Serial (7) can end STOP.
  localparam logic [15:0] STOP_WAKE_MASK = 16'h3080;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       pend;
  logic       wake_halt;
  logic       wake_stop;

  // Lowest set bit wins: lower source numbers have higher priority.
  function automatic logic [3:0] lowest_bit(input logic [15:0] v);
    lowest_bit = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_bit = 4'(i);
    end
  endfunction

  assign pend      = (|irq_pending) & ime;
  assign wake_halt = |irq_pending;
  assign wake_stop = |(irq_pending & STOP_WAKE_MASK);

  // State and shared delay counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; a STOP request always beats a simultaneous HALT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_RUN, S_DELAY, S_ASSERT: begin
        if (stop_req) begin
          state_nxt = S_STOP;
        end else if (halt_req) begin
          state_nxt = S_HALT;
        end else if (state == S_RUN) begin
          if (pend) begin
            if (IRQ_DELAY == 0) begin
              state_nxt = S_ASSERT;
            end else begin
              state_nxt = S_DELAY;
              cnt_nxt   = IRQ_LOAD;
            end
          end
        end else if (state == S_DELAY) begin
          if (!pend)              state_nxt = S_RUN;
          else if (cnt == 4'd0)   state_nxt = S_ASSERT;
          else                    cnt_nxt   = cnt - 4'd1;
        end else begin
          if (cpu_irq_ack || !pend) state_nxt = S_RUN;
        end
      end
      S_HALT, S_STOP: begin
        if ((state == S_HALT) ? wake_halt : wake_stop) begin
          if (WAKE_DELAY == 0) begin
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_WAKE;
            cnt_nxt   = WAKE_LOAD;
          end
        end
      end
      S_WAKE: begin
        if (cnt == 4'd0) state_nxt = S_RUN;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: begin
        state_nxt = S_RUN;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Latch the winning source only on the transition into ASSERT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_source <= 4'd0;
    end else if (state_nxt == S_ASSERT && state != S_ASSERT) begin
      irq_source <= lowest_bit(irq_pending);
    end
  end

  // Saturating halted-cycle counter; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_cycles <= 32'd0;
    end else if (halt_cycles_clr) begin
      halt_cycles <= 32'd0;
    end else if (halt && !(&halt_cycles)) begin
      halt_cycles <= halt_cycles + 32'd1;
    end
  end

  // Outputs decode directly from the registered state.
  always_comb begin
    cpu_irq   = (state == S_ASSERT);
    halt      = (state == S_HALT) || (state == S_STOP) || (state == S_WAKE);
    stop      = (state == S_STOP);
    state_dbg = state;
  end

endmodule

// File: tb/tb_gba_irq_scheduler.sv
// Directed testbench for gba_irq_scheduler: a vector table for the main
// sequences plus hand sequences for async reset and zero-delay parameters.
module tb_gba_irq_scheduler;

  localparam logic [2:0] RUN = 3'd0, DLY = 3'd1, ASR = 3'd2,
                         HLT = 3'd3, STP = 3'd4, WAK = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] irq_pending;
  logic        ime, cpu_irq_ack, halt_req, stop_req, halt_cycles_clr;
  logic        cpu_irq, halt, stop;
  logic [3:0]  irq_source;
  logic [31:0] halt_cycles;
  logic [2:0]  state_dbg;
  logic        z_cpu_irq, z_halt, z_stop;
  logic [3:0]  z_irq_source;
  logic [31:0] z_halt_cycles;
  logic [2:0]  z_state_dbg;

  int checks = 0;
  int errors = 0;

  gba_irq_scheduler #(.IRQ_DELAY(3), .WAKE_DELAY(2)) dut (
    .clk(clk), .reset(reset), .irq_pending(irq_pending), .ime(ime),
    .cpu_irq_ack(cpu_irq_ack), .halt_req(halt_req), .stop_req(stop_req),
    .halt_cycles_clr(halt_cycles_clr), .cpu_irq(cpu_irq),
    .irq_source(irq_source), .halt(halt), .stop(stop),
    .halt_cycles(halt_cycles), .state_dbg(state_dbg)
  );

  gba_irq_scheduler #(.IRQ_DELAY(0), .WAKE_DELAY(0)) dut_z (
    .clk(clk), .reset(reset), .irq_pending(irq_pending), .ime(ime),
    .cpu_irq_ack(cpu_irq_ack), .halt_req(halt_req), .stop_req(stop_req),
    .halt_cycles_clr(halt_cycles_clr), .cpu_irq(z_cpu_irq),
    .irq_source(z_irq_source), .halt(z_halt), .stop(z_stop),
    .halt_cycles(z_halt_cycles), .state_dbg(z_state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pend;
    logic        ime, ack, hreq, sreq, clr;
    logic [2:0]  st;
    logic        irq;
    logic [3:0]  src;
    logic        h, s;
    logic [31:0] hc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [15:0] pend, logic ime, logic ack,
                              logic hreq, logic sreq, logic clr,
                              logic [2:0] st, logic irq, logic [3:0] src,
                              logic h, logic s, logic [31:0] hc);
    vec_t v;
    v.pend = pend; v.ime = ime; v.ack = ack; v.hreq = hreq; v.sreq = sreq;
    v.clr = clr; v.st = st; v.irq = irq; v.src = src; v.h = h; v.s = s;
    v.hc = hc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    irq_pending = 16'h0; ime = 1'b0; cpu_irq_ack = 1'b0;
    halt_req = 1'b0; stop_req = 1'b0; halt_cycles_clr = 1'b0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    irq_pending = v.pend; ime = v.ime; cpu_irq_ack = v.ack;
    halt_req = v.hreq; stop_req = v.sreq; halt_cycles_clr = v.clr;
  endtask

  initial begin
    //              pend    ime ack hr sr clr state irq src h  s  hc
    tbl.push_back(mk(16'h0001,1,0,0,0,0, DLY,0,0,0,0,0));
    tbl.push_back(mk(16'h0001,1,0,0,0,0, DLY,0,0,0,0,0));
    tbl.push_back(mk(16'h0001,1,0,0,0,0, DLY,0,0,0,0,0));
    tbl.push_back(mk(16'h0001,1,0,0,0,0, ASR,1,0,0,0,0));
    tbl.push_back(mk(16'h0001,1,0,0,0,0, ASR,1,0,0,0,0));
    tbl.push_back(mk(16'h0001,1,1,0,0,0, RUN,0,0,0,0,0));
    tbl.push_back(mk(16'h0110,1,0,0,0,0, DLY,0,0,0,0,0));
    tbl.push_back(mk(16'h0110,1,0,0,0,0, DLY,0,0,0,0,0));
    tbl.push_back(mk(16'h0110,1,0,0,0,0, DLY,0,0,0,0,0));
    tbl.push_back(mk(16'h0110,1,0,0,0,0, ASR,1,4,0,0,0));
    tbl.push_back(mk(16'h0100,1,1,0,0,0, RUN,0,4,0,0,0));
    tbl.push_back(mk(16'h0100,1,0,0,0,0, DLY,0,4,0,0,0));
    tbl.push_back(mk(16'h0100,1,0,0,0,0, DLY,0,4,0,0,0));
    tbl.push_back(mk(16'h0100,1,0,0,0,0, DLY,0,4,0,0,0));
    tbl.push_back(mk(16'h0100,1,0,0,0,0, ASR,1,8,0,0,0));
    tbl.push_back(mk(16'h0000,1,0,0,0,0, RUN,0,8,0,0,0));
    tbl.push_back(mk(16'h0004,1,0,0,0,0, DLY,0,8,0,0,0));
    tbl.push_back(mk(16'h0004,1,0,0,0,0, DLY,0,8,0,0,0));
    tbl.push_back(mk(16'h0000,1,0,0,0,0, RUN,0,8,0,0,0));
    tbl.push_back(mk(16'h0000,1,0,0,0,0, RUN,0,8,0,0,0));
    tbl.push_back(mk(16'h0000,1,1,0,0,0, RUN,0,8,0,0,0));
    tbl.push_back(mk(16'h0000,0,0,1,0,0, HLT,0,8,1,0,0));
    tbl.push_back(mk(16'h0000,0,0,0,0,0, HLT,0,8,1,0,1));
    tbl.push_back(mk(16'h0008,0,0,0,0,0, WAK,0,8,1,0,2));
    tbl.push_back(mk(16'h0008,0,0,0,0,0, WAK,0,8,1,0,3));
    tbl.push_back(mk(16'h0008,0,0,0,0,0, RUN,0,8,0,0,4));
    tbl.push_back(mk(16'h0008,0,0,0,0,0, RUN,0,8,0,0,4));
    tbl.push_back(mk(16'h0008,1,0,0,0,0, DLY,0,8,0,0,4));
    tbl.push_back(mk(16'h0008,1,0,0,0,0, DLY,0,8,0,0,4));
    tbl.push_back(mk(16'h0008,1,0,0,0,0, DLY,0,8,0,0,4));
    tbl.push_back(mk(16'h0008,1,0,0,0,0, ASR,1,3,0,0,4));
    tbl.push_back(mk(16'h0000,1,0,0,0,0, RUN,0,3,0,0,4));
    tbl.push_back(mk(16'h0000,1,0,0,1,0, STP,0,3,1,1,4));
    tbl.push_back(mk(16'h0001,1,0,0,0,0, STP,0,3,1,1,5));
    tbl.push_back(mk(16'h0001,1,0,0,0,0, STP,0,3,1,1,6));
    tbl.push_back(mk(16'h1000,1,0,0,0,0, WAK,0,3,1,0,7));
    tbl.push_back(mk(16'h0000,1,0,0,0,0, WAK,0,3,1,0,8));
    tbl.push_back(mk(16'h0000,1,0,0,0,0, RUN,0,3,0,0,9));
    tbl.push_back(mk(16'h0000,1,0,1,1,0, STP,0,3,1,1,9));
    tbl.push_back(mk(16'h2000,1,0,0,0,0, WAK,0,3,1,0,10));
    tbl.push_back(mk(16'h0000,1,0,1,0,0, WAK,0,3,1,0,11));
    tbl.push_back(mk(16'h0000,1,0,0,0,0, RUN,0,3,0,0,12));
    tbl.push_back(mk(16'h0001,0,0,1,0,0, HLT,0,3,1,0,12));
    tbl.push_back(mk(16'h0001,0,0,0,0,0, WAK,0,3,1,0,13));
    tbl.push_back(mk(16'h0000,0,0,0,0,0, WAK,0,3,1,0,14));
    tbl.push_back(mk(16'h0000,0,0,0,0,0, RUN,0,3,0,0,15));
    tbl.push_back(mk(16'h0000,0,0,0,0,1, RUN,0,3,0,0,0));
    tbl.push_back(mk(16'h0001,1,0,0,0,0, DLY,0,3,0,0,0));
    tbl.push_back(mk(16'h0001,1,0,1,0,0, HLT,0,3,1,0,0));
    tbl.push_back(mk(16'h0001,1,0,0,0,0, WAK,0,3,1,0,1));
    tbl.push_back(mk(16'h0000,1,0,0,0,0, WAK,0,3,1,0,2));
    tbl.push_back(mk(16'h0000,1,0,0,0,0, RUN,0,3,0,0,3));
    tbl.push_back(mk(16'h0000,0,0,1,0,0, HLT,0,3,1,0,3));
    tbl.push_back(mk(16'h0000,0,0,0,0,1, HLT,0,3,1,0,0));
    tbl.push_back(mk(16'h0000,0,0,0,0,0, HLT,0,3,1,0,1));
    tbl.push_back(mk(16'h0080,0,0,0,0,0, WAK,0,3,1,0,2));
    tbl.push_back(mk(16'h0000,0,0,0,0,0, WAK,0,3,1,0,3));
    tbl.push_back(mk(16'h0000,0,0,0,0,0, RUN,0,3,0,0,4));

    // Reset
    clear_inputs();
    reset = 1'b1;
    #1;
    chk("reset cpu_irq", {31'd0, cpu_irq}, 32'd0);
    chk("reset halt", {31'd0, halt}, 32'd0);
    chk("reset stop", {31'd0, stop}, 32'd0);
    chk("reset src", {28'd0, irq_source}, 32'd0);
    chk("reset hc", halt_cycles, 32'd0);
    chk("reset state", {29'd0, state_dbg}, {29'd0, RUN});
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      step();
      chk($sformatf("v%0d state", i), {29'd0, state_dbg}, {29'd0, tbl[i].st});
      chk($sformatf("v%0d cpu_irq", i), {31'd0, cpu_irq}, {31'd0, tbl[i].irq});
      chk($sformatf("v%0d src", i), {28'd0, irq_source}, {28'd0, tbl[i].src});
      chk($sformatf("v%0d halt", i), {31'd0, halt}, {31'd0, tbl[i].h});
      chk($sformatf("v%0d stop", i), {31'd0, stop}, {31'd0, tbl[i].s});
      chk($sformatf("v%0d hc", i), halt_cycles, tbl[i].hc);
    end

    // Async reset mid-ASSERT
    clear_inputs();
    irq_pending = 16'h0002; ime = 1'b1;
    repeat (4) step();
    chk("pre-reset assert", {31'd0, cpu_irq}, 32'd1);
    chk("pre-reset src", {28'd0, irq_source}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async rst cpu_irq", {31'd0, cpu_irq}, 32'd0);
    chk("async rst src", {28'd0, irq_source}, 32'd0);
    clear_inputs();
    reset = 1'b0;

    // Async reset mid-HALT
    step();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    step();
    chk("pre-reset halt", {31'd0, halt}, 32'd1);
    chk("pre-reset hc", halt_cycles, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async rst halt", {31'd0, halt}, 32'd0);
    chk("async rst hc", halt_cycles, 32'd0);
    reset = 1'b0;

    // Async reset mid-STOP
    step();
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    chk("pre-reset stop", {31'd0, stop}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async rst stop", {31'd0, stop}, 32'd0);
    chk("async rst stop halt", {31'd0, halt}, 32'd0);
    chk("async rst state", {29'd0, state_dbg}, {29'd0, RUN});
    reset = 1'b0;
    step();

    // Zero-delay instance: pend goes straight to ASSERT, wake straight to RUN
    irq_pending = 16'h0020; ime = 1'b1;
    step();
    chk("z assert", {31'd0, z_cpu_irq}, 32'd1);
    chk("z src", {28'd0, z_irq_source}, 32'd5);
    irq_pending = 16'h0000;
    step();
    chk("z drop", {31'd0, z_cpu_irq}, 32'd0);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("z halt", {31'd0, z_halt}, 32'd1);
    irq_pending = 16'h0001; ime = 1'b0;
    step();
    chk("z wake", {31'd0, z_halt}, 32'd0);
    chk("z hc", z_halt_cycles, 32'd1);
    irq_pending = 16'h0000;
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    chk("z stop", {31'd0, z_stop}, 32'd1);
    irq_pending = 16'h0001;
    step();
    chk("z stop hold", {31'd0, z_stop}, 32'd1);
    irq_pending = 16'h0080;
    step();
    chk("z stop wake", {31'd0, z_stop}, 32'd0);
    chk("z stop halt", {31'd0, z_halt}, 32'd0);
    chk("z state", {29'd0, z_state_dbg}, {29'd0, RUN});
    clear_inputs();
    step();

    // Report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
